// File: rtl/sprite_wr_sched.sv
// sprite_wr_sched: queues sprite-table writes from EXE and commits them to video only during vblank.
// Build macro SPR_COALESCE_EN: a request for the same sprite as the newest queued entry overwrites it in place.
module sprite_wr_sched #(
   parameter int DEPTH = 8,
   parameter int SEL_W = 6
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    spr_req,
   input  logic [SEL_W-1:0]        spr_sel,
   input  logic [9:0]              spr_x,
   input  logic [8:0]              spr_y,
   input  logic [2:0]              spr_flags,
   input  logic                    vblank,
   input  logic                    vid_ready,
   output logic                    stall_o,
   output logic                    vid_we,
   output logic [SEL_W-1:0]        vid_sel,
   output logic [9:0]              vid_x,
   output logic [8:0]              vid_y,
   output logic [2:0]              vid_flags,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    frame_done
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int ENT_W = SEL_W + 22;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WAIT  = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             frame_done_q, frame_done_d;
   logic [ENT_W-1:0] mem_q [DEPTH];
   logic [ENT_W-1:0] mem_d [DEPTH];
   logic [ENT_W-1:0] head, new_ent;
   logic             full, empty, pop, push, coal;

   // Queue status, offer/accept handshake and push/stall decision
   always_comb begin
      full    = (count_q == CNT_W'(DEPTH));
      empty   = (count_q == CNT_W'(0));
      head    = mem_q[rd_ptr_q];
      new_ent = {spr_sel, spr_x, spr_y, spr_flags};
      vid_we  = (state_q == S_DRAIN) & vblank & ~empty;
      pop     = vid_we & vid_ready;
`ifdef SPR_COALESCE_EN
      // Newest entry is only off-limits when it is also the head leaving this cycle
      coal    = spr_req & ~empty
                & (mem_q[wr_ptr_q - PTR_W'(1)][ENT_W-1 -: SEL_W] == spr_sel)
                & ~(pop & (count_q == CNT_W'(1)));
`else
      coal    = 1'b0;
`endif
      push    = spr_req & ~full & ~coal;
      stall_o = spr_req & full & ~coal;
   end

   // Storage, pointers, occupancy and drain-complete pulse
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) begin
         mem_d[wr_ptr_q] = new_ent;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end else if (coal) begin
         mem_d[wr_ptr_q - PTR_W'(1)] = new_ent;
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
      frame_done_d = pop & ~push & (count_q == CNT_W'(1));
   end

   // Commit FSM next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (push) begin
               state_d = vblank ? S_DRAIN : S_WAIT;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_WAIT: begin
            if (vblank) begin
               state_d = S_DRAIN;
            end else begin
               state_d = S_WAIT;
            end
         end
         S_DRAIN: begin
            if (count_d == CNT_W'(0)) begin
               state_d = S_IDLE;
            end else if (!vblank) begin
               state_d = S_WAIT;
            end else begin
               state_d = S_DRAIN;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Offered write fields are zero whenever nothing is offered
   always_comb begin
      if (vid_we) begin
         {vid_sel, vid_x, vid_y, vid_flags} = head;
      end else begin
         {vid_sel, vid_x, vid_y, vid_flags} = {ENT_W{1'b0}};
      end
   end

   assign count      = count_q;
   assign frame_done = frame_done_q;

   // Control state registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         wr_ptr_q     <= {PTR_W{1'b0}};
         rd_ptr_q     <= {PTR_W{1'b0}};
         count_q      <= {CNT_W{1'b0}};
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         frame_done_q <= frame_done_d;
      end
   end

   // Entry storage needs no reset: contents are dead once the pointers clear
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end
endmodule

// File: tb/tb_sprite_wr_sched.sv
// Self-checking bench for sprite_wr_sched: queue-level reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_sprite_wr_sched;
   localparam int DEPTH = 8;
   localparam int SEL_W = 6;
`ifdef SPR_COALESCE_EN
   localparam bit COAL = 1'b1;
`else
   localparam bit COAL = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic spr_req = 1'b0;
   logic [SEL_W-1:0] spr_sel = '0;
   logic [9:0] spr_x = '0;
   logic [8:0] spr_y = '0;
   logic [2:0] spr_flags = '0;
   logic vblank = 1'b0;
   logic vid_ready = 1'b1;
   logic stall_o, vid_we, frame_done;
   logic [SEL_W-1:0] vid_sel;
   logic [9:0] vid_x;
   logic [8:0] vid_y;
   logic [2:0] vid_flags;
   logic [$clog2(DEPTH):0] count;

   sprite_wr_sched #(.DEPTH(DEPTH), .SEL_W(SEL_W)) dut (
      .clk(clk), .reset(reset), .spr_req(spr_req), .spr_sel(spr_sel),
      .spr_x(spr_x), .spr_y(spr_y), .spr_flags(spr_flags), .vblank(vblank),
      .vid_ready(vid_ready), .stall_o(stall_o), .vid_we(vid_we), .vid_sel(vid_sel),
      .vid_x(vid_x), .vid_y(vid_y), .vid_flags(vid_flags), .count(count),
      .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   // Reference model: pending writes in issue order, whether the head may be offered,
   // the expected frame_done, and the log of writes the model committed.
   logic [27:0] mq[$];
   bit drain_en = 1'b0;
   bit fd_exp = 1'b0;
   logic [27:0] mlog[$];
   logic [SEL_W-1:0] dlog[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [27:0] pk(input int s, input int x, input int y, input int f);
      return {6'(s), 10'(x), 9'(y), 3'(f)};
   endfunction

   function automatic bit m_pop();
      return drain_en && vblank && (mq.size() > 0) && vid_ready;
   endfunction

   function automatic bit m_coal();
      logic [27:0] t;
      if (!COAL || !spr_req || mq.size() == 0) return 1'b0;
      t = mq[mq.size()-1];
      return (t[27:22] == spr_sel) && !(m_pop() && mq.size() == 1);
   endfunction

   initial begin : model_proc
      bit p, c, pu;
      int sz;
      forever begin
         @(posedge clk);
         if (reset) begin
            mq.delete();
            drain_en = 1'b0;
            fd_exp = 1'b0;
         end else begin
            p  = m_pop();
            c  = m_coal();
            sz = mq.size();
            pu = spr_req && (sz < DEPTH) && !c;
            fd_exp = p && !pu && (sz == 1);
            if (p) begin
               mlog.push_back(mq[0]);
               void'(mq.pop_front());
            end
            if (c) mq[mq.size()-1] = {spr_sel, spr_x, spr_y, spr_flags};
            if (pu) mq.push_back({spr_sel, spr_x, spr_y, spr_flags});
            drain_en = vblank && (mq.size() > 0);
         end
      end
   end

   initial begin : cmp_proc
      logic [27:0] h;
      bit we;
      int sz;
      forever begin
         @(negedge clk);
         #2;
         if (cmp_en) begin
            sz = mq.size();
            we = drain_en && vblank && (sz > 0);
            h = 28'd0;
            if (we) h = mq[0];
            chk("vid_we", vid_we, we);
            chk("vid_sel", vid_sel, h[27:22]);
            chk("vid_x", vid_x, h[21:12]);
            chk("vid_y", vid_y, h[11:3]);
            chk("vid_flags", vid_flags, h[2:0]);
            chk("stall_o", stall_o, spr_req && (sz == DEPTH) && !m_coal());
            chk("count", count, sz);
            chk("frame_done", frame_done, fd_exp);
            if (vid_we && vid_ready) dlog.push_back(vid_sel);
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic put(input int s, input int x, input int y, input int f);
      spr_req = 1'b1;
      spr_sel = 6'(s);
      spr_x = 10'(x);
      spr_y = 9'(y);
      spr_flags = 3'(f);
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while (count != 0 && n < budget) begin
         tick();
         n++;
      end
      chk("drain_within_budget", (n < budget), 1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [27:0] t;
      tick();
      tick();
      reset = 1'b0;
      cmp_en = 1'b1;
      chk("rst_count", count, 0);
      chk("rst_vid_we", vid_we, 0);
      chk("rst_stall", stall_o, 0);
      chk("rst_frame_done", frame_done, 0);

      // 1: single push outside vblank
      put(3, 100, 50, 5);
      tick();
      spr_req = 1'b0;
      chk("t1_count", count, 1);
      chk("t1_vid_we", vid_we, 0);

      // 2: vblank drains it with a frame_done pulse
      vblank = 1'b1;
      vid_ready = 1'b1;
      tick();
      chk("t2_vid_we", vid_we, 1);
      chk("t2_sel", vid_sel, 3);
      chk("t2_x", vid_x, 100);
      chk("t2_y", vid_y, 50);
      chk("t2_flags", vid_flags, 5);
      tick();
      chk("t2_count", count, 0);
      chk("t2_frame_done", frame_done, 1);
      tick();
      chk("t2_fd_one_cycle", frame_done, 0);
      chk("t2_idle_we", vid_we, 0);

      // 3/5: DEPTH+1 requests, stall on the 9th, push+pop at full still stalls
      vblank = 1'b0;
      mlog.delete();
      dlog.delete();
      for (int i = 0; i < DEPTH; i++) begin
         put(i, i * 10 + 1, i + 2, i);
         tick();
      end
      put(8, 81, 10, 2);
      vblank = 1'b1;
      #1;
      chk("t3_stall_9th", stall_o, 1);
      chk("t3_full", count, 8);
      tick();
      chk("t3_offer_sel0", vid_sel, 0);
      chk("t5_stall_at_full_pop", stall_o, 1);
      tick();
      chk("t5_count_after_pop", count, 7);
      tick();
      chk("t3_9th_accepted", count, 7);
      spr_req = 1'b0;
      drain(30);
      chk("t3_frame_done", frame_done, 1);
      chk("t3_dut_writes", dlog.size(), 9);
      chk("t3_model_writes", mlog.size(), 9);
      for (int i = 0; i < 9 && i < dlog.size(); i++) chk("t3_order", dlog[i], i);

      // 4: withdrawn offer stays at head and is reissued next vblank
      vblank = 1'b0;
      vid_ready = 1'b0;
      dlog.delete();
      put(7, 7, 7, 1);
      tick();
      put(9, 9, 9, 2);
      tick();
      spr_req = 1'b0;
      vblank = 1'b1;
      tick();
      chk("t4_offer", vid_we, 1);
      chk("t4_offer_sel", vid_sel, 7);
      tick();
      vblank = 1'b0;
      tick();
      chk("t4_withdrawn", vid_we, 0);
      chk("t4_kept", count, 2);
      vid_ready = 1'b1;
      vblank = 1'b1;
      tick();
      chk("t4_reissue_sel", vid_sel, 7);
      chk("t4_reissue_x", vid_x, 7);
      drain(10);
      chk("t4_writes", dlog.size(), 2);
      if (dlog.size() == 2) begin
         chk("t4_first", dlog[0], 7);
         chk("t4_second", dlog[1], 9);
      end

      // 6: same-sprite requests (coalesced when enabled), then reset mid-drain
      vblank = 1'b0;
      mlog.delete();
      put(5, 10, 1, 1);
      tick();
      put(5, 20, 1, 1);
      tick();
      put(6, 30, 1, 1);
      tick();
      spr_req = 1'b0;
      chk("t6_count", count, COAL ? 2 : 3);
      vblank = 1'b1;
      vid_ready = 1'b0;
      tick();
      chk("t6_head_x", vid_x, COAL ? 20 : 10);
      vid_ready = 1'b1;
      tick();
      chk("t6_model_pops", mlog.size(), 1);
      if (mlog.size() == 1) begin
         t = mlog[0];
         chk("t6_model_x", t[21:12], COAL ? 20 : 10);
      end
      reset = 1'b1;
      tick();
      chk("t6_rst_count", count, 0);
      chk("t6_rst_we", vid_we, 0);
      reset = 1'b0;
      vblank = 1'b0;
      tick();
      chk("t6_post_count", count, 0);
      chk("t6_post_fd", frame_done, 0);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
